// File: rtl/v68k_bus_pkg.sv
// V68k bus encodings and the prefetch state type, shared by the core and other bus masters.
package v68k_bus_pkg;

  localparam logic AS_STROBE = 1'b0;
  localparam logic AS_OFF    = 1'b1;
  localparam logic DS_ON     = 1'b0;
  localparam logic DS_OFF    = 1'b1;
  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

  localparam logic [2:0] FC_NONE       = 3'b000;
  localparam logic [2:0] FC_USER_DATA  = 3'b001;
  localparam logic [2:0] FC_USER_PROG  = 3'b010;
  localparam logic [2:0] FC_SUPER_DATA = 3'b101;
  localparam logic [2:0] FC_SUPER_PROG = 3'b110;
  localparam logic [2:0] FC_INT_ACK    = 3'b111;

  localparam int PC_W = 23;
  localparam int IW_W = 16;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_ADDR,
    PF_WAIT,
    PF_TERM
  } pf_state_t;

  // Word addresses wrap from the top of the 16 MB space back to zero.
  function automatic logic [PC_W-1:0] next_word_pc(input logic [PC_W-1:0] pc);
    return pc + 23'd1;
  endfunction

endpackage

// File: rtl/v68k_word_fifo.sv
// DEPTH-entry FIFO of {instruction word, word address}; clear wins over push and pop.
module v68k_word_fifo
  import v68k_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = IW_W + PC_W
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/v68k_prefetch.sv
// Instruction prefetch: runs 68000 read cycles for sequential words into a small queue for decode.
// Optional V68K_PREFETCH_BERR_EN: BERR ends a fetch cycle, flags bus_err and halts fetching until flush.
module v68k_prefetch
  import v68k_bus_pkg::*;
#(
  parameter int         DEPTH   = 2,
  parameter logic [2:0] FC_PROG = 3'b110
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        flush,
  input  logic [22:0] flush_pc,
  input  logic        iw_ready,
  output logic        iw_valid,
  output logic [15:0] iw_data,
  output logic [22:0] iw_pc,
  output logic [22:0] A,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [2:0]  FC,
  input  logic [15:0] D,
  input  logic        DTACK,
  input  logic        BERR,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  pf_state_t          state;
  logic [22:0]        fetch_pc;
  logic               armed;
  logic               discard;
  logic               ds;
  logic [CNT_W-1:0]   count;
  logic [38:0]        head;
  logic [CNT_W:0]     used;
  logic               in_flight;
  logic               space;
  logic               start_ok;
  logic [22:0]        next_pc;
  logic               ack;
  logic               berr_hit;
  logic               push;
  logic               pop;

  // A cycle whose word will be dropped does not hold a queue slot.
  assign in_flight = ((state == PF_ADDR) || (state == PF_WAIT)) && !discard;
  assign used      = {1'b0, count} + (CNT_W + 1)'(in_flight);
  assign space     = used < (CNT_W + 1)'(DEPTH);
  assign start_ok  = flush || (armed && space);
  assign next_pc   = flush ? flush_pc : fetch_pc;
  assign ack       = (state == PF_WAIT) && DTACK;

`ifdef V68K_PREFETCH_BERR_EN
  assign berr_hit = (state == PF_WAIT) && !DTACK && BERR;
`else
  assign berr_hit = BERR & 1'b0;
`endif

  assign push     = ack && !discard && !flush;
  assign pop      = iw_valid && iw_ready && !flush;
  assign iw_valid = (count != '0);
  assign {iw_data, iw_pc} = head;
  assign UDS = ds;
  assign LDS = ds;
  assign RW  = RW_READ;

  v68k_word_fifo #(.DEPTH(DEPTH), .WIDTH(39)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear     (flush),
    .push      (push),
    .push_data ({D, fetch_pc}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // An error on a cycle that is being discarded belongs to the abandoned stream, so it is not reported.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= PF_IDLE;
      A        <= '0;
      AS       <= AS_OFF;
      ds       <= DS_OFF;
      FC       <= FC_NONE;
      fetch_pc <= '0;
      armed    <= 1'b0;
      discard  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (flush) begin
        fetch_pc <= flush_pc;
        armed    <= 1'b1;
        bus_err  <= 1'b0;
      end else if (push) begin
        fetch_pc <= next_word_pc(fetch_pc);
      end
      case (state)
        PF_IDLE, PF_TERM: begin
          if (start_ok) begin
            state <= PF_ADDR;
            A     <= next_pc;
            AS    <= AS_STROBE;
            ds    <= DS_ON;
            FC    <= FC_PROG;
          end else begin
            state <= PF_IDLE;
          end
        end
        PF_ADDR: begin
          state <= PF_WAIT;
          if (flush) discard <= 1'b1;
        end
        PF_WAIT: begin
          if (ack || berr_hit) begin
            state   <= PF_TERM;
            AS      <= AS_OFF;
            ds      <= DS_OFF;
            FC      <= FC_NONE;
            discard <= 1'b0;
            if (berr_hit && !discard && !flush) begin
              bus_err <= 1'b1;
              armed   <= 1'b0;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= PF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v68k_prefetch.sv
// Scoreboard bench for v68k_prefetch: randomized memory responder, decode model and bus-pin monitor.
module tb_v68k_prefetch;

  localparam int         DEPTH   = 2;
  localparam logic [2:0] FC_PROG = 3'b110;

  logic        CLK = 1'b0;
  logic        RESET, flush, iw_ready, iw_valid;
  logic [22:0] flush_pc, iw_pc, A;
  logic [15:0] iw_data, D;
  logic        AS, UDS, LDS, RW, DTACK, BERR, bus_err;
  logic [2:0]  FC;

  v68k_prefetch #(.DEPTH(DEPTH), .FC_PROG(FC_PROG)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .flush_pc(flush_pc),
    .iw_ready(iw_ready), .iw_valid(iw_valid), .iw_data(iw_data), .iw_pc(iw_pc),
    .A(A), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .FC(FC),
    .D(D), .DTACK(DTACK), .BERR(BERR), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [22:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [22:0] fetch_addrs[$];
  int          checks = 0;
  int          passes = 0;
  int          pops = 0;
  int          as_low = 0;
  int          dtack_wait = -1;
  bit          berr_armed = 1'b0;
  logic [22:0] berr_addr = '0;

  // Memory contents: every word address holds a distinct pattern.
  function automatic logic [15:0] word_of(input logic [22:0] pc);
    return pc[15:0] ^ {pc[22:16], 9'h15A};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // After a flush decode must see the word stream flush_pc, flush_pc+1, ... with wrap at 23 bits.
  task automatic modelFlush(input logic [22:0] pc);
    logic [22:0] p;
    exp_t e;
    exp_q.delete();
    p = pc;
    for (int i = 0; i < 200; i++) begin
      e.pc   = p;
      e.data = word_of(p);
      exp_q.push_back(e);
      p = p + 23'd1;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit fl, input logic [22:0] pc);
    RESET    = rst;
    flush    = fl;
    flush_pc = pc;
    if (rst) exp_q.delete();
    if (fl) modelFlush(pc);
    step();
    RESET = 1'b0;
    flush = 1'b0;
  endtask

  task automatic waitAsLowAt(input logic [22:0] addr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (AS == 1'b0 && A == addr) ok = 1'b1;
      else step();
    end
  endtask

  task automatic waitFetches(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (fetch_addrs.size() >= n) ok = 1'b1;
      else step();
    end
  endtask

  // Memory responder: DTACK (or BERR at berr_addr) after a programmable number of strobed cycles.
  initial begin
    int low_cnt;
    int cur_wait;
    low_cnt  = 0;
    cur_wait = 0;
    DTACK = 1'b0;
    BERR  = 1'b0;
    D     = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (AS == 1'b0) low_cnt++;
      else low_cnt = 0;
      if (low_cnt == 1) cur_wait = (dtack_wait < 0) ? int'($urandom_range(0, 3)) : dtack_wait;
      D = word_of(A);
      if (AS == 1'b0 && low_cnt > cur_wait) begin
        if (berr_armed && A == berr_addr) begin
          BERR  = 1'b1;
          DTACK = 1'b0;
        end else begin
          BERR  = 1'b0;
          DTACK = 1'b1;
        end
      end else begin
        DTACK = 1'b0;
        BERR  = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on handshakes, plus bus pin and output-hold rules every cycle.
  initial begin
    logic        prev_as;
    logic [22:0] prev_a;
    bit          prev_hold;
    logic [38:0] prev_head;
    exp_t        e;
    prev_as   = 1'b1;
    prev_a    = '0;
    prev_hold = 1'b0;
    prev_head = '0;
    forever begin
      @(negedge CLK);
      if (!RESET && !flush && iw_valid && iw_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checkOutput("pop_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("iw_pc", 64'(iw_pc), 64'(e.pc));
          checkOutput("iw_data", 64'(iw_data), 64'(e.data));
        end
      end
      if (prev_hold) checkOutput("iw_hold", 64'({iw_data, iw_pc}), 64'(prev_head));
      checkOutput("bus_pins", 64'({UDS, LDS, RW, FC}), 64'({AS, AS, 1'b1, (AS ? 3'b000 : FC_PROG)}));
      if (prev_as == 1'b0 && AS == 1'b0) checkOutput("addr_stable", 64'(A), 64'(prev_a));
      if (prev_as == 1'b1 && AS == 1'b0) fetch_addrs.push_back(A);
      if (AS == 1'b0) as_low++;
      prev_hold = iw_valid && !iw_ready && !flush && !RESET;
      prev_head = {iw_data, iw_pc};
      prev_as   = AS;
      prev_a    = A;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int p0, l0, n0;
    RESET    = 1'b1;
    flush    = 1'b0;
    flush_pc = '0;
    iw_ready = 1'b0;

    // Reset state and no fetching before the first flush.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("reset_bus", 64'({A, AS, UDS, LDS, RW, FC}), 64'({23'd0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000}));
    checkOutput("reset_iw_valid", 64'(iw_valid), 64'd0);
    checkOutput("reset_bus_err", 64'(bus_err), 64'd0);
    fetch_addrs.delete();
    for (int i = 0; i < 10; i++) step();
    checkOutput("no_fetch_before_flush", 64'(fetch_addrs.size()), 64'd0);

    // Test 1: queue fills with two words, then the bus goes quiet.
    dtack_wait = 2;
    applyStimulus(1'b0, 1'b1, 23'h000200);
    for (int i = 0; i < 20; i++) step();
    checkOutput("t1_fetch_count", 64'(fetch_addrs.size()), 64'(DEPTH));
    if (fetch_addrs.size() >= 2) begin
      checkOutput("t1_addr0", 64'(fetch_addrs[0]), 64'h200);
      checkOutput("t1_addr1", 64'(fetch_addrs[1]), 64'h201);
    end
    checkOutput("t1_head", 64'({iw_valid, iw_pc}), 64'({1'b1, 23'h000200}));
    for (int i = 0; i < 10; i++) step();
    checkOutput("t1_as_quiet", 64'(fetch_addrs.size()), 64'(DEPTH));
    iw_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // Test 2: zero-wait memory with decode always ready gives one word per three clocks.
    applyStimulus(1'b1, 1'b0, '0);
    dtack_wait = 0;
    iw_ready   = 1'b1;
    applyStimulus(1'b0, 1'b1, 23'h000200);
    for (int i = 0; i < 8; i++) step();
    p0 = pops;
    l0 = as_low;
    for (int i = 0; i < 30; i++) step();
    checkOutput("t2_pops_per_30", 64'(pops - p0), 64'd10);
    checkOutput("t2_as_low_per_30", 64'(as_low - l0), 64'd20);

    // Test 3: flush during WAIT drops the in-flight word; next fetch is at the new PC.
    applyStimulus(1'b1, 1'b0, '0);
    dtack_wait = 3;
    applyStimulus(1'b0, 1'b1, 23'h000200);
    waitAsLowAt(23'h000203, 60, ok);
    checkOutput("t3_reach_0x203", 64'(ok), 64'd1);
    step();
    n0 = fetch_addrs.size();
    applyStimulus(1'b0, 1'b1, 23'h000800);
    checkOutput("t3_valid_after_flush", 64'(iw_valid), 64'd0);
    waitFetches(n0 + 1, 20, ok);
    checkOutput("t3_refetch", 64'(ok), 64'd1);
    if (ok) checkOutput("t3_new_addr", 64'(fetch_addrs[n0]), 64'h800);
    p0 = pops;
    for (int i = 0; i < 25; i++) step();
    checkOutput("t3_progress", 64'(pops - p0 >= 2), 64'd1);

    // Test 4: word address wraps from 0x7FFFFF to 0.
    dtack_wait = -1;
    fetch_addrs.delete();
    applyStimulus(1'b0, 1'b1, 23'h7FFFFF);
    waitFetches(2, 30, ok);
    checkOutput("t4_fetches", 64'(ok), 64'd1);
    if (ok) begin
      checkOutput("t4_addr_top", 64'(fetch_addrs[0]), 64'h7FFFFF);
      checkOutput("t4_addr_wrap", 64'(fetch_addrs[1]), 64'h0);
    end
    p0 = pops;
    for (int i = 0; i < 15; i++) step();
    checkOutput("t4_progress", 64'(pops - p0 >= 2), 64'd1);

`ifdef V68K_PREFETCH_BERR_EN
    // Test 5: bus error halts fetching, queued words still drain, flush recovers.
    applyStimulus(1'b1, 1'b0, '0);
    dtack_wait = 1;
    iw_ready   = 1'b0;
    berr_armed = 1'b1;
    berr_addr  = 23'h000300;
    fetch_addrs.delete();
    applyStimulus(1'b0, 1'b1, 23'h0002FF);
    for (int i = 0; i < 25; i++) step();
    checkOutput("t5_bus_err", 64'(bus_err), 64'd1);
    checkOutput("t5_fetch_count", 64'(fetch_addrs.size()), 64'd2);
    checkOutput("t5_head", 64'({iw_valid, iw_pc}), 64'({1'b1, 23'h0002FF}));
    for (int i = 0; i < 10; i++) step();
    checkOutput("t5_halted", 64'(fetch_addrs.size()), 64'd2);
    p0 = pops;
    iw_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checkOutput("t5_drained", 64'({iw_valid, 8'(pops - p0)}), 64'({1'b0, 8'd1}));
    berr_armed = 1'b0;
    applyStimulus(1'b0, 1'b1, 23'h000400);
    checkOutput("t5_err_cleared", 64'(bus_err), 64'd0);
    n0 = fetch_addrs.size();
    waitFetches(n0 + 1, 20, ok);
    checkOutput("t5_resumed", 64'(ok), 64'd1);
`endif

    // Test 6: reset in the middle of a cycle drops strobes at once and disarms fetching.
    applyStimulus(1'b1, 1'b0, '0);
    dtack_wait = 3;
    iw_ready   = 1'b1;
    applyStimulus(1'b0, 1'b1, 23'h000100);
    waitAsLowAt(23'h000100, 10, ok);
    checkOutput("t6_started", 64'(ok), 64'd1);
    step();
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("t6_strobes", 64'({AS, UDS, LDS, iw_valid, bus_err}), 64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
    n0 = fetch_addrs.size();
    for (int i = 0; i < 12; i++) step();
    checkOutput("t6_no_fetch", 64'(fetch_addrs.size()), 64'(n0));

    // Randomized run: random decode backpressure, memory latency and flush targets.
    dtack_wait = -1;
    applyStimulus(1'b0, 1'b1, 23'($urandom));
    for (int i = 0; i < 600; i++) begin
      iw_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, 1'b1, 23'h7FFFFC + 23'($urandom_range(0, 3)));
        else applyStimulus(1'b0, 1'b1, 23'($urandom));
      end else begin
        step();
      end
    end
    iw_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
